// File: rtl/lcd_pkg.sv
// Shared FSM state encoding and default frame constants for the LCD frame fetcher.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_CHECK = 3'd2,
    ST_REQ   = 3'd3,
    ST_BUSY  = 3'd4,
    ST_HOLD  = 3'd5
  } fetch_state_t;

  localparam int LCD_FRAME_WORDS = 640 * 480;
  localparam int LCD_BURST_LEN   = 256;

endpackage

// File: rtl/lcd_fetch_ctrl_if.sv
// Burst read request channel between the LCD fetcher (master) and the SDRAM controller (slave).
interface lcd_fetch_ctrl_if #(
  parameter int ADDR_W  = 22,
  parameter int LEVEL_W = 10
);

  logic               rd_req;
  logic [ADDR_W-1:0]  rd_addr;
  logic [LEVEL_W-1:0] rd_len;
  logic               rd_ack;
  logic               rd_done;

  modport master (
    output rd_req,
    output rd_addr,
    output rd_len,
    input  rd_ack,
    input  rd_done
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    input  rd_len,
    output rd_ack,
    output rd_done
  );

endinterface

// File: rtl/lcd_fetch_addr_gen.sv
// Frame address bookkeeping: base/offset/remaining registers and the next burst address/length.
// Address and length are combinational from the registers, so they stay fixed while a request waits.
module lcd_fetch_addr_gen
  import lcd_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int LEVEL_W     = 10,
  parameter int BURST_LEN   = LCD_BURST_LEN,
  parameter int FRAME_WORDS = LCD_FRAME_WORDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_base,
  input  logic               start,
  input  logic               advance,
  input  logic [ADDR_W-1:0]  frame_base,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [LEVEL_W-1:0] rd_len,
  output logic               rem_zero
);

  localparam int REM_W = $clog2(FRAME_WORDS + 1);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] offset;
  logic [REM_W-1:0]  remaining;

  always_ff @(posedge clk) begin
    if (rst) begin
      base      <= '0;
      offset    <= '0;
      remaining <= '0;
    end else begin
      if (load_base) base <= frame_base;
      if (start) begin
        offset    <= '0;
        remaining <= REM_W'(FRAME_WORDS);
      end else if (advance) begin
        offset    <= offset + ADDR_W'(rd_len);
        remaining <= remaining - REM_W'(rd_len);
      end
    end
  end

  // Short final burst carries whatever is left of the frame.
  always_comb begin
    if (32'(remaining) < 32'(BURST_LEN)) rd_len = LEVEL_W'(remaining);
    else                                 rd_len = LEVEL_W'(BURST_LEN);
  end

  assign rd_addr  = base + offset;
  assign rem_zero = (remaining == '0);

endmodule

// File: rtl/lcd_fetch_ctrl.sv
// LCD line-FIFO refill controller: one SDRAM burst outstanding, restart on frame sync.
// Optional LCD_FETCH_UNDERFLOW_CNT_EN adds a saturating 16-bit underflow event counter.
module lcd_fetch_ctrl
  import lcd_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int LEVEL_W     = 10,
  parameter int BURST_LEN   = LCD_BURST_LEN,
  parameter int FRAME_WORDS = LCD_FRAME_WORDS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   frame_base,
  input  logic                lcd_framesync,
  input  logic                lcd_request,
  input  logic [LEVEL_W:0]    fifo_level,
  output logic                fifo_clr,
  output logic                underflow,
`ifdef LCD_FETCH_UNDERFLOW_CNT_EN
  output logic [15:0]         underflow_cnt,
`endif
  lcd_fetch_ctrl_if.master    rd
);

  localparam logic [LEVEL_W:0] REFILL_THRESH = (LEVEL_W+1)'((1 << LEVEL_W) - BURST_LEN);

  fetch_state_t state, state_n;
  logic pending, set_pend, clr_pend;
  logic load_base, start, advance, rem_zero;
  logic uf_evt;

  lcd_fetch_addr_gen #(
    .ADDR_W      (ADDR_W),
    .LEVEL_W     (LEVEL_W),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load_base  (load_base),
    .start      (start),
    .advance    (advance),
    .frame_base (frame_base),
    .rd_addr    (rd.rd_addr),
    .rd_len     (rd.rd_len),
    .rem_zero   (rem_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
    end else begin
      state <= state_n;
      if (clr_pend)      pending <= 1'b0;
      else if (set_pend) pending <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    fifo_clr  = 1'b0;
    rd.rd_req = 1'b0;
    load_base = 1'b0;
    start     = 1'b0;
    advance   = 1'b0;
    set_pend  = 1'b0;
    clr_pend  = 1'b0;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (lcd_framesync) begin
          load_base = 1'b1;
          start     = 1'b1;
          state_n   = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        fifo_clr = 1'b1;
        if (lcd_framesync) begin
          load_base = 1'b1;
          start     = 1'b1;
        end
        state_n = ST_CHECK;
      end
      ST_CHECK: begin
        if (lcd_framesync) begin
          load_base = 1'b1;
          start     = 1'b1;
          state_n   = ST_FLUSH;
        end else if (rem_zero) begin
          state_n = ST_HOLD;
        end else if (fifo_level <= REFILL_THRESH) begin
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        // An ack in the same cycle as frame sync commits the burst; restart after it lands.
        if (rd.rd_ack) begin
          rd.rd_req = 1'b1;
          state_n   = ST_BUSY;
          if (lcd_framesync) begin
            load_base = 1'b1;
            set_pend  = 1'b1;
          end
        end else if (lcd_framesync) begin
          load_base = 1'b1;
          start     = 1'b1;
          state_n   = ST_FLUSH;
        end else begin
          rd.rd_req = 1'b1;
        end
      end
      ST_BUSY: begin
        if (lcd_framesync) begin
          load_base = 1'b1;
          set_pend  = 1'b1;
        end
        if (rd.rd_done) begin
          if (pending || lcd_framesync) begin
            start    = 1'b1;
            clr_pend = 1'b1;
            set_pend = 1'b0;
            state_n  = ST_FLUSH;
          end else begin
            advance = 1'b1;
            state_n = ST_CHECK;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign uf_evt = lcd_request && (fifo_level == '0) &&
                  (state == ST_CHECK || state == ST_REQ || state == ST_BUSY || state == ST_HOLD);

  always_ff @(posedge clk) begin
    if (rst)                    underflow <= 1'b0;
    else if (state == ST_FLUSH) underflow <= 1'b0;
    else if (uf_evt)            underflow <= 1'b1;
  end

`ifdef LCD_FETCH_UNDERFLOW_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                              underflow_cnt <= '0;
    else if (uf_evt && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lcd_fetch_ctrl.sv
// Directed bench for lcd_fetch_ctrl with a 1000-word frame so a whole frame fits in a short run.
module tb_lcd_fetch_ctrl;
  import lcd_pkg::*;

  localparam int ADDR_W  = 22;
  localparam int LEVEL_W = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic [ADDR_W-1:0]   frame_base;
  logic                lcd_framesync;
  logic                lcd_request;
  logic [LEVEL_W:0]    fifo_level;
  logic                fifo_clr;
  logic                underflow;
`ifdef LCD_FETCH_UNDERFLOW_CNT_EN
  logic [15:0]         underflow_cnt;
`endif

  int checks = 0;
  int errors = 0;

  lcd_fetch_ctrl_if #(.ADDR_W(ADDR_W), .LEVEL_W(LEVEL_W)) rd ();

  lcd_fetch_ctrl #(
    .ADDR_W      (ADDR_W),
    .LEVEL_W     (LEVEL_W),
    .BURST_LEN   (256),
    .FRAME_WORDS (1000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_base    (frame_base),
    .lcd_framesync (lcd_framesync),
    .lcd_request   (lcd_request),
    .fifo_level    (fifo_level),
    .fifo_clr      (fifo_clr),
    .underflow     (underflow),
`ifdef LCD_FETCH_UNDERFLOW_CNT_EN
    .underflow_cnt (underflow_cnt),
`endif
    .rd            (rd.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_sync(input logic [ADDR_W-1:0] base);
    frame_base    = base;
    lcd_framesync = 1'b1;
    tick();
    lcd_framesync = 1'b0;
  endtask

  // Wait (bounded) for a request, check it, then ack and complete it immediately.
  task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] exp_len);
    int n = 0;
    while (rd.rd_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"},  32'(rd.rd_req), 32'd1);
    chk({tag, "_addr"}, 32'(rd.rd_addr), exp_addr);
    chk({tag, "_len"},  32'(rd.rd_len), exp_len);
    rd.rd_ack = 1'b1;
    tick();
    rd.rd_ack  = 1'b0;
    rd.rd_done = 1'b1;
    tick();
    rd.rd_done = 1'b0;
  endtask

  initial begin
    logic seen;
    rst = 1'b1; frame_base = '0; lcd_framesync = 1'b0; lcd_request = 1'b0;
    fifo_level = '0; rd.rd_ack = 1'b0; rd.rd_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_req",   32'(rd.rd_req), 32'd0);
    chk("rst_clr",   32'(fifo_clr),  32'd0);
    chk("rst_uf",    32'(underflow), 32'd0);
    chk("rst_addr",  32'(rd.rd_addr), 32'd0);
    chk("rst_len",   32'(rd.rd_len), 32'd0);
`ifdef LCD_FETCH_UNDERFLOW_CNT_EN
    chk("rst_cnt",   32'(underflow_cnt), 32'd0);
`endif

    // Frame start: FLUSH, CHECK, then REQ.
    pulse_sync(22'h100000);
    chk("flush_clr", 32'(fifo_clr), 32'd1);
    chk("flush_req", 32'(rd.rd_req), 32'd0);
    tick();
    chk("check_clr", 32'(fifo_clr), 32'd0);
    chk("check_req", 32'(rd.rd_req), 32'd0);
    tick();
    chk("first_req",  32'(rd.rd_req), 32'd1);
    chk("first_addr", 32'(rd.rd_addr), 32'h100000);
    chk("first_len",  32'(rd.rd_len), 32'd256);
    tick();
    chk("req_stable_addr", 32'(rd.rd_addr), 32'h100000);

    // Whole frame of 1000 words: 256, 256, 256, 232.
    serve("b0", 32'h100000, 32'd256);
    serve("b1", 32'h100100, 32'd256);
    serve("b2", 32'h100200, 32'd256);
    serve("b3", 32'h100300, 32'd232);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rd.rd_req !== 1'b0) seen = 1'b1;
    end
    chk("hold_no_req", 32'(seen), 32'd0);

    // Refill threshold for depth 1024 / burst 256 is 768.
    fifo_level = 11'd769;
    pulse_sync(22'h000200);
    tick();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rd.rd_req !== 1'b0) seen = 1'b1;
    end
    chk("thresh_769_no_req", 32'(seen), 32'd0);
    fifo_level = 11'd768;
    tick();
    chk("thresh_768_req",  32'(rd.rd_req), 32'd1);
    chk("thresh_768_addr", 32'(rd.rd_addr), 32'h000200);

    // Accept and sit in BUSY; underflow events there.
    rd.rd_ack = 1'b1;
    tick();
    rd.rd_ack = 1'b0;
    fifo_level  = '0;
    lcd_request = 1'b1;
    tick();
    lcd_request = 1'b0;
    chk("uf_set", 32'(underflow), 32'd1);
`ifdef LCD_FETCH_UNDERFLOW_CNT_EN
    chk("uf_cnt1", 32'(underflow_cnt), 32'd1);
`endif
    tick();
    chk("uf_held", 32'(underflow), 32'd1);
    lcd_request = 1'b1;
    tick();
    lcd_request = 1'b0;
`ifdef LCD_FETCH_UNDERFLOW_CNT_EN
    chk("uf_cnt2", 32'(underflow_cnt), 32'd2);
    lcd_request = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    lcd_request = 1'b0;
    chk("uf_cnt_sat", 32'(underflow_cnt), 32'hFFFF);
`endif

    // Frame sync during BUSY waits for rd_done before flushing.
    pulse_sync(22'h000400);
    seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (fifo_clr !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("busy_no_clr", 32'(seen), 32'd0);
    rd.rd_done = 1'b1;
    tick();
    rd.rd_done = 1'b0;
    chk("busy_restart_clr", 32'(fifo_clr), 32'd1);
    tick();
    chk("uf_cleared", 32'(underflow), 32'd0);
    tick();
    chk("restart_req",  32'(rd.rd_req), 32'd1);
    chk("restart_addr", 32'(rd.rd_addr), 32'h000400);
    chk("restart_len",  32'(rd.rd_len), 32'd256);

    // Frame sync in REQ without ack drops rd_req the same cycle.
    frame_base    = 22'h000800;
    lcd_framesync = 1'b1;
    #1;
    chk("req_drop", 32'(rd.rd_req), 32'd0);
    tick();
    lcd_framesync = 1'b0;
    chk("req_abort_clr", 32'(fifo_clr), 32'd1);
    tick();
    tick();
    chk("req_abort_addr", 32'(rd.rd_addr), 32'h000800);

    // Address wrap at 2^22.
    pulse_sync(22'h3FFF80);
    serve("w0", 32'h3FFF80, 32'd256);
    serve("w1", 32'h000080, 32'd256);

    // Ack and frame sync together: burst commits, restart follows rd_done.
    tick();
    chk("ack_sync_pre", 32'(rd.rd_req), 32'd1);
    frame_base    = 22'h000000;
    rd.rd_ack     = 1'b1;
    lcd_framesync = 1'b1;
    #1;
    chk("ack_wins_req", 32'(rd.rd_req), 32'd1);
    tick();
    rd.rd_ack     = 1'b0;
    lcd_framesync = 1'b0;
    chk("ack_wins_no_clr", 32'(fifo_clr), 32'd0);
    rd.rd_done = 1'b1;
    tick();
    rd.rd_done = 1'b0;
    chk("ack_wins_clr", 32'(fifo_clr), 32'd1);
    tick();
    tick();
    chk("ack_wins_addr", 32'(rd.rd_addr), 32'h000000);
    chk("ack_wins_len",  32'(rd.rd_len), 32'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
